pipe_controller: RTL and testbench
==================================

Name: pipe_controller

Overview:
- Pipelined successor to the single-cycle CPU controller.
- Decodes the ID-stage instruction into a control word, then carries it through EX, MEM and WB registers.
- Detects load-use hazards (stall) and resolves branches and jumps in EX (flush, PC redirect).
- Sits between the fetch/ID register and the datapath stage registers of the pipelined 8-bit CPU.

Parameters:
- INSTR_W, 8, instruction width; opcode is instr[INSTR_W-1:INSTR_W-5].
- REG_W, 3, register field width; the field is instr[REG_W-1:0] and serves as source in ID and destination in EX.
- FLAG_W, 4, ALU flag width; bit 0 is the zero flag.
- ALUC_W, 4, ALU control width.
- BR_PENALTY, 2, flush cycles after a taken branch or jump (1..7).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  ID instruction valid; 0 means bubble.
- instr  in  INSTR_W  ID-stage instruction.
- aluflags  in  FLAG_W  flags from the EX-stage ALU.
- stall  out  1  hold PC and IF/ID register.
- flush  out  1  squash IF/ID contents.
- pccontrol  out  3  PC select: 0 = PC+1, 1 = branch target, 2 = jump target.
- ex_alucontrol  out  ALUC_W  EX-stage ALU operation.
- ex_imm  out  1  EX-stage immediate operand select.
- mem_we  out  1  MEM-stage memory write enable.
- mem_load  out  1  MEM-stage load.
- wb_regwe  out  1  WB-stage register write enable.
- wb_regchange  out  1  WB-stage write-data select.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset); it is sampled only at the rising edge of clk.
- Reset values: all stage registers are cleared to a bubble (all-zero control word). All outputs are 0. State is RUN and the penalty counter is 0.
- Latency:
  - The ID decode is registered into EX on the next edge.
  - EX advances to MEM, and MEM to WB, one cycle each.
  - EX outputs are valid in cycle N+1 for an instruction presented in ID at cycle N.
- Bubbles: instr_valid=0 decodes to an all-zero control word.
- Load-use stall:
  - Condition: EX is OP_LOAD, ID is valid, and the ID source field equals the EX destination field.
  - Response: stall=1 combinationally, a bubble is inserted into EX, and ID is held (the instruction is re-presented the next cycle).
  - Lasts exactly 1 cycle.
- Branch resolution in EX:
  - OP_BEQ is taken when aluflags[0]=1; OP_J is always taken.
  - On taken: pccontrol=1 (BEQ) or 2 (J) for that one cycle, flush=1, a bubble goes into EX, and the FSM enters FLUSH with counter=BR_PENALTY-1.
  - A not-taken branch gives pccontrol=0.
- FSM states:
  - RUN: normal operation.
  - FLUSH: flush=1 and a bubble into EX every cycle; the counter decrements and the FSM returns to RUN when it reaches 0.
  - BR_PENALTY=1 never enters FLUSH.
- Priority: flush beats stall. A taken branch in EX during a stall condition gives stall=0 and flush=1.
- Downstream: MEM and WB always advance; only EX accepts bubbles.
- Reset mid-FLUSH: returns to RUN with the pipeline cleared on the next edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined: adds outputs perf_stalls (16 bits) and perf_flushes (16 bits). These are saturating counts of stall-asserted and flush-asserted cycles, cleared by reset.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef struct ctrl_t {alucontrol, imm, memwe, load, regwe, regchange, is_branch, is_jump}.
  - typedef enum {RUN, FLUSH}.
  - Opcode constants: OP_ADD=5'b00000, OP_LOAD=5'b01000, OP_STORE=5'b01001, OP_BEQ=5'b10000, OP_J=5'b10010.
  - CTRL_BUBBLE constant (all-zero control word).
- Sub-module ctrl_decode: combinational opcode to ctrl_t.

Test Plan:
- Reset: reset=1 for 2 cycles with random instr -> every output is 0 and the state is RUN.
- Straight-line flow: OP_ADD presented at cycle 0 -> wb_regwe=1 at cycle 3, stall=0 and flush=0 throughout.
- Load-use: OP_LOAD dest=3, then OP_ADD src=3 -> stall=1 for exactly 1 cycle, EX holds a bubble, and the ADD reaches EX one cycle late. With OP_ADD src=2 instead -> no stall.
- Taken branch: OP_BEQ with aluflags=4'b0001 in EX, BR_PENALTY=2 -> pccontrol=1 and flush=1 that cycle, flush=1 the next cycle, then RUN. With aluflags=0 -> pccontrol=0 and no flush.
- Branch beats stall: OP_J in EX while a load-use condition is also present -> flush=1, stall=0, pccontrol=2.
- Reset mid-FLUSH, plus the perf option: reset during FLUSH -> RUN next cycle. With PIPE_CTRL_PERF_EN defined: 3 stalls and 2 flush cycles -> perf_stalls=3 and perf_flushes=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined CPU controller.
package pipe_ctrl_pkg;

    localparam int unsigned CTRL_ALUC_W = 4;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_LOAD  = 5'b01000;
    localparam logic [4:0] OP_STORE = 5'b01001;
    localparam logic [4:0] OP_BEQ   = 5'b10000;
    localparam logic [4:0] OP_J     = 5'b10010;

    // ALU operation encodings driven onto ex_alucontrol
    localparam logic [CTRL_ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_ALUC_W-1:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic [CTRL_ALUC_W-1:0] alucontrol;
        logic                   imm;
        logic                   memwe;
        logic                   load;
        logic                   regwe;
        logic                   regchange;
        logic                   is_branch;
        logic                   is_jump;
    } ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: ID-stage opcode to control word.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic       instr_valid,
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    // Unknown opcodes and invalid slots decode to a bubble
    always_comb begin
        ctrl = CTRL_BUBBLE;
        if (instr_valid) begin
            unique case (opcode)
                OP_ADD: begin
                    ctrl.alucontrol = ALU_ADD;
                    ctrl.regwe      = 1'b1;
                end
                OP_LOAD: begin
                    ctrl.alucontrol = ALU_ADD;
                    ctrl.imm        = 1'b1;
                    ctrl.load       = 1'b1;
                    ctrl.regwe      = 1'b1;
                    ctrl.regchange  = 1'b1;
                end
                OP_STORE: begin
                    ctrl.alucontrol = ALU_ADD;
                    ctrl.imm        = 1'b1;
                    ctrl.memwe      = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.alucontrol = ALU_SUB;
                    ctrl.is_branch  = 1'b1;
                end
                OP_J: begin
                    ctrl.is_jump = 1'b1;
                end
                default: ctrl = CTRL_BUBBLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined CPU controller: ID decode, EX/MEM/WB control registers,
// load-use stall and EX-stage branch/jump resolution with flush.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W    = 8,
    parameter int unsigned REG_W      = 3,
    parameter int unsigned FLAG_W     = 4,
    parameter int unsigned ALUC_W     = 4,
    parameter int unsigned BR_PENALTY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [FLAG_W-1:0]  aluflags,
    output logic               stall,
    output logic               flush,
    output logic [2:0]         pccontrol,
    output logic [ALUC_W-1:0]  ex_alucontrol,
    output logic               ex_imm,
    output logic               mem_we,
    output logic               mem_load,
    output logic               wb_regwe,
`ifdef PIPE_CTRL_PERF_EN
    output logic               wb_regchange,
    output logic [15:0]        perf_stalls,
    output logic [15:0]        perf_flushes
`else
    output logic               wb_regchange
`endif
);

    ctrl_t            id_ctrl;
    ctrl_t            ex_q;
    logic [REG_W-1:0] ex_dst_q;
    logic             mem_we_q, mem_load_q, mem_regwe_q, mem_regchange_q;
    logic             wb_regwe_q, wb_regchange_q;
    state_t           state_q;
    logic [2:0]       cnt_q;
    logic             take, hazard;
    logic             unused_flags;

    assign unused_flags = ^aluflags[FLAG_W-1:1];

    ctrl_decode u_decode (
        .instr_valid (instr_valid),
        .opcode      (instr[INSTR_W-1:INSTR_W-5]),
        .ctrl        (id_ctrl)
    );

    // Hazard and redirect decisions; a redirect always overrides a stall
    always_comb begin
        take      = ex_q.is_jump | (ex_q.is_branch & aluflags[0]);
        hazard    = ex_q.load & instr_valid & (instr[REG_W-1:0] == ex_dst_q);
        flush     = take | (state_q == FLUSH);
        stall     = hazard & ~flush;
        pccontrol = 3'd0;
        if (ex_q.is_jump) begin
            pccontrol = 3'd2;
        end else if (take) begin
            pccontrol = 3'd1;
        end
    end

    // Flush FSM: stays in FLUSH for the remaining penalty cycles after a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (take && BR_PENALTY > 1) begin
                        state_q <= FLUSH;
                        cnt_q   <= 3'(BR_PENALTY - 1);
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Stage registers: EX takes a bubble on stall or flush; MEM and WB always advance
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q            <= CTRL_BUBBLE;
            ex_dst_q        <= '0;
            mem_we_q        <= 1'b0;
            mem_load_q      <= 1'b0;
            mem_regwe_q     <= 1'b0;
            mem_regchange_q <= 1'b0;
            wb_regwe_q      <= 1'b0;
            wb_regchange_q  <= 1'b0;
        end else begin
            ex_q            <= (stall || flush) ? CTRL_BUBBLE : id_ctrl;
            ex_dst_q        <= instr[REG_W-1:0];
            mem_we_q        <= ex_q.memwe;
            mem_load_q      <= ex_q.load;
            mem_regwe_q     <= ex_q.regwe;
            mem_regchange_q <= ex_q.regchange;
            wb_regwe_q      <= mem_regwe_q;
            wb_regchange_q  <= mem_regchange_q;
        end
    end

    assign ex_alucontrol = ALUC_W'(ex_q.alucontrol);
    assign ex_imm        = ex_q.imm;
    assign mem_we        = mem_we_q;
    assign mem_load      = mem_load_q;
    assign wb_regwe      = wb_regwe_q;
    assign wb_regchange  = wb_regchange_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_stalls_q, perf_flushes_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (stall && perf_stalls_q != 16'hFFFF) begin
                perf_stalls_q <= perf_stalls_q + 16'd1;
            end
            if (flush && perf_flushes_q != 16'hFFFF) begin
                perf_flushes_q <= perf_flushes_q + 16'd1;
            end
        end
    end

    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed self-checking bench for pipe_controller (BR_PENALTY = 2).
module tb_pipe_controller;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic [3:0] aluflags;
    logic       stall, flush;
    logic [2:0] pccontrol;
    logic [3:0] ex_alucontrol;
    logic       ex_imm, mem_we, mem_load, wb_regwe, wb_regchange;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_stalls, perf_flushes;
`endif

    int total = 0;
    int bad   = 0;

    pipe_controller dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .aluflags      (aluflags),
        .stall         (stall),
        .flush         (flush),
        .pccontrol     (pccontrol),
        .ex_alucontrol (ex_alucontrol),
        .ex_imm        (ex_imm),
        .mem_we        (mem_we),
        .mem_load      (mem_load),
        .wb_regwe      (wb_regwe),
`ifdef PIPE_CTRL_PERF_EN
        .wb_regchange  (wb_regchange),
        .perf_stalls   (perf_stalls),
        .perf_flushes  (perf_flushes)
`else
        .wb_regchange  (wb_regchange)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with random inputs
        reset = 1'b1; instr_valid = 1'b1; instr = 8'($urandom); aluflags = 4'($urandom);
        step();
        instr = 8'($urandom); aluflags = 4'($urandom);
        step();
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_flush", 16'(flush), 16'd0);
        chk("rst_pc", 16'(pccontrol), 16'd0);
        chk("rst_alu", 16'(ex_alucontrol), 16'd0);
        chk("rst_misc", 16'({ex_imm, mem_we, mem_load, wb_regwe, wb_regchange}), 16'd0);
        chk("rst_state", 16'(dut.state_q), 16'(RUN));
        reset = 1'b0; instr_valid = 1'b0; aluflags = 4'd0;
        step();

        // Straight-line ADD: EX next cycle, WB three cycles later
        instr = 8'h01; instr_valid = 1'b1; #1;
        chk("add_id_sf", 16'({stall, flush}), 16'd0);
        step(); instr_valid = 1'b0; #1;
        chk("add_ex_alu", 16'(ex_alucontrol), 16'(ALU_ADD));
        chk("add_ex_sf", 16'({stall, flush}), 16'd0);
        step(); #1;
        chk("add_mem_wb", 16'(wb_regwe), 16'd0);
        step(); #1;
        chk("add_wb_regwe", 16'(wb_regwe), 16'd1);
        chk("add_wb_chg", 16'(wb_regchange), 16'd0);

        // Load-use: LOAD r3 then ADD r3 -> one stall cycle
        instr = 8'h43; instr_valid = 1'b1;
        step(); instr = 8'h03; #1;
        chk("lu_stall", 16'(stall), 16'd1);
        chk("lu_flush", 16'(flush), 16'd0);
        chk("lu_ex_imm", 16'(ex_imm), 16'd1);
        step(); #1;
        chk("lu_stall_once", 16'(stall), 16'd0);
        chk("lu_ex_bubble", 16'(ex_alucontrol), 16'd0);
        chk("lu_mem_load", 16'(mem_load), 16'd1);
        step(); instr_valid = 1'b0; #1;
        chk("lu_ex_add_late", 16'(ex_alucontrol), 16'(ALU_ADD));
        chk("lu_wb_load", 16'({wb_regwe, wb_regchange}), 16'b11);
        step(); step();

        // LOAD r3 then ADD r2 -> no stall
        instr = 8'h43; instr_valid = 1'b1;
        step(); instr = 8'h02; #1;
        chk("nolu_stall", 16'(stall), 16'd0);
        step(); instr_valid = 1'b0; #1;
        chk("nolu_ex_add", 16'(ex_alucontrol), 16'(ALU_ADD));
        step(); step();

        // Taken BEQ: redirect + two flush cycles
        instr = 8'h80; instr_valid = 1'b1; aluflags = 4'd0;
        step(); instr = 8'h05; aluflags = 4'b0001; #1;
        chk("beq_ex_alu", 16'(ex_alucontrol), 16'(ALU_SUB));
        chk("beq_pc", 16'(pccontrol), 16'd1);
        chk("beq_flush", 16'(flush), 16'd1);
        chk("beq_stall", 16'(stall), 16'd0);
        step(); instr_valid = 1'b0; aluflags = 4'd0; #1;
        chk("beq_flush2", 16'(flush), 16'd1);
        chk("beq_squash", 16'(ex_alucontrol), 16'd0);
        chk("beq_pc2", 16'(pccontrol), 16'd0);
        chk("beq_state_fl", 16'(dut.state_q), 16'(FLUSH));
        step(); #1;
        chk("beq_flush3", 16'(flush), 16'd0);
        chk("beq_state_run", 16'(dut.state_q), 16'(RUN));

        // Not-taken BEQ
        instr = 8'h80; instr_valid = 1'b1;
        step(); instr = 8'h05; aluflags = 4'd0; #1;
        chk("bnt_pc", 16'(pccontrol), 16'd0);
        chk("bnt_flush", 16'(flush), 16'd0);
        step(); instr_valid = 1'b0; #1;
        chk("bnt_ex_add", 16'(ex_alucontrol), 16'(ALU_ADD));
        step(); step();

        // Jump in EX with a matching register field in ID: flush wins
        instr = 8'h93; instr_valid = 1'b1;
        step(); instr = 8'h03; #1;
        chk("j_stall", 16'(stall), 16'd0);
        chk("j_flush", 16'(flush), 16'd1);
        chk("j_pc", 16'(pccontrol), 16'd2);
        step(); instr_valid = 1'b0; #1;
        chk("j_flush2", 16'(flush), 16'd1);
        chk("j_squash", 16'(ex_alucontrol), 16'd0);
        step();

        // Reset during FLUSH
        instr = 8'h90; instr_valid = 1'b1;
        step(); instr_valid = 1'b0; #1;
        chk("rf_take", 16'(flush), 16'd1);
        step(); #1;
        chk("rf_in_flush", 16'(dut.state_q), 16'(FLUSH));
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        chk("rf_state_run", 16'(dut.state_q), 16'(RUN));
        chk("rf_flush_off", 16'(flush), 16'd0);
        chk("rf_ex_clear", 16'(ex_alucontrol), 16'd0);

`ifdef PIPE_CTRL_PERF_EN
        // Three load-use stalls, then one jump (two flush cycles)
        for (int i = 0; i < 3; i++) begin
            instr = 8'h43; instr_valid = 1'b1;
            step(); instr = 8'h03;
            step();
            step(); instr_valid = 1'b0;
        end
        instr = 8'h90; instr_valid = 1'b1;
        step(); instr_valid = 1'b0;
        step();
        step(); #1;
        chk("perf_stalls", perf_stalls, 16'd3);
        chk("perf_flushes", perf_flushes, 16'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
